// File: rtl/fifo_sync_flex.sv
// Single-clock FIFO with arbitrary depth, standard or first-word-fall-through read,
// occupancy count, almost-full/almost-empty flags and overflow/underflow pulses.
module fifo_sync_flex #(
  parameter int unsigned DataWidth         = 32,
  parameter int unsigned FifoDepth         = 8,
  parameter int unsigned AlmostFullThresh  = 6,
  parameter int unsigned AlmostEmptyThresh = 2,
  parameter bit          FwftMode          = 1'b0,
  localparam int unsigned CountW           = $clog2(FifoDepth + 1)
) (
  input  logic                 clk,
  input  logic                 i_rst_n,
  input  logic                 i_write,
  input  logic [DataWidth-1:0] i_write_data,
  input  logic                 i_read,
  output logic [DataWidth-1:0] o_read_data,
  output logic                 o_read_valid,
  output logic                 o_full,
  output logic                 o_empty,
  output logic                 o_almost_full,
  output logic                 o_almost_empty,
  output logic [CountW-1:0]    o_count,
  output logic                 o_overflow,
  output logic                 o_underflow
);

  if (FifoDepth < 2) begin : g_bad_depth
    $error("fifo_sync_flex: FifoDepth must be >= 2");
  end
  if (AlmostFullThresh < 1 || AlmostFullThresh > FifoDepth) begin : g_bad_af
    $error("fifo_sync_flex: AlmostFullThresh must be in 1..FifoDepth");
  end
  if (AlmostEmptyThresh > FifoDepth - 1) begin : g_bad_ae
    $error("fifo_sync_flex: AlmostEmptyThresh must be in 0..FifoDepth-1");
  end

  localparam int unsigned          PtrW    = $clog2(FifoDepth);
  localparam logic [PtrW-1:0]      LastPtr = PtrW'(FifoDepth - 1);
  localparam logic [CountW-1:0]    FullCnt = CountW'(FifoDepth);
  localparam logic [CountW-1:0]    AfCnt   = CountW'(AlmostFullThresh);
  localparam logic [CountW-1:0]    AeCnt   = CountW'(AlmostEmptyThresh);

  logic [DataWidth-1:0] mem_q [FifoDepth];
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CountW-1:0]    count_q, count_d;
  logic                 overflow_q, overflow_d, underflow_q, underflow_d;
  logic                 read_en, write_en;

  always_comb begin
    read_en     = i_read && (count_q != '0);
    // A full FIFO still accepts a write when a read frees a slot in the same cycle.
    write_en    = i_write && ((count_q != FullCnt) || read_en);
    overflow_d  = i_write && !write_en;
    underflow_d = i_read && !read_en;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    if (write_en) wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrW'(1);
    if (read_en)  rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrW'(1);
    case ({write_en, read_en})
      2'b10:   count_d = count_q + CountW'(1);
      2'b01:   count_d = count_q - CountW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (write_en) mem_q[wr_ptr_q] <= i_write_data;
  end

  if (FwftMode) begin : g_fwft
    // Gate the head word so unwritten storage never reaches the output.
    assign o_read_data  = (count_q == '0) ? '0 : mem_q[rd_ptr_q];
    assign o_read_valid = (count_q != '0);
  end else begin : g_std
    logic [DataWidth-1:0] rd_data_q, rd_data_d;
    logic                 rd_valid_q, rd_valid_d;

    always_comb begin
      rd_data_d  = read_en ? mem_q[rd_ptr_q] : rd_data_q;
      rd_valid_d = read_en;
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_data_q  <= rd_data_d;
        rd_valid_q <= rd_valid_d;
      end
    end

    assign o_read_data  = rd_data_q;
    assign o_read_valid = rd_valid_q;
  end

  assign o_count        = count_q;
  assign o_full         = (count_q == FullCnt);
  assign o_empty        = (count_q == '0);
  assign o_almost_full  = (count_q >= AfCnt);
  assign o_almost_empty = (count_q <= AeCnt);
  assign o_overflow     = overflow_q;
  assign o_underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_sync_flex.sv
// Directed bench for fifo_sync_flex: one standard-mode and one FWFT instance,
// both 8-bit wide, depth 5, thresholds 3/1.
module tb_fifo_sync_flex;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  logic       s_wr, s_rd, s_valid, s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
  logic [7:0] s_wdata, s_rdata;
  logic [2:0] s_count;
  logic       f_wr, f_rd, f_valid, f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
  logic [7:0] f_wdata, f_rdata;
  logic [2:0] f_count;

  fifo_sync_flex #(
    .DataWidth(8), .FifoDepth(5), .AlmostFullThresh(3), .AlmostEmptyThresh(1), .FwftMode(1'b0)
  ) u_std (
    .clk(clk), .i_rst_n(rst_n), .i_write(s_wr), .i_write_data(s_wdata), .i_read(s_rd),
    .o_read_data(s_rdata), .o_read_valid(s_valid), .o_full(s_full), .o_empty(s_empty),
    .o_almost_full(s_af), .o_almost_empty(s_ae), .o_count(s_count), .o_overflow(s_ovf),
    .o_underflow(s_unf)
  );

  fifo_sync_flex #(
    .DataWidth(8), .FifoDepth(5), .AlmostFullThresh(3), .AlmostEmptyThresh(1), .FwftMode(1'b1)
  ) u_fwft (
    .clk(clk), .i_rst_n(rst_n), .i_write(f_wr), .i_write_data(f_wdata), .i_read(f_rd),
    .o_read_data(f_rdata), .o_read_valid(f_valid), .o_full(f_full), .o_empty(f_empty),
    .o_almost_full(f_af), .o_almost_empty(f_ae), .o_count(f_count), .o_overflow(f_ovf),
    .o_underflow(f_unf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    total++; if (s_count !== 3'd0) begin bad++; $display("FAIL rst_std_count got=%0d want=0", s_count); end
    total++; if ({s_full, s_empty, s_af, s_ae} !== 4'b0101) begin
      bad++; $display("FAIL rst_std_flags got=%b want=0101", {s_full, s_empty, s_af, s_ae}); end
    total++; if ({s_valid, s_ovf, s_unf} !== 3'b000) begin
      bad++; $display("FAIL rst_std_pulses got=%b want=000", {s_valid, s_ovf, s_unf}); end
    total++; if (s_rdata !== 8'h00) begin bad++; $display("FAIL rst_std_data got=%h want=00", s_rdata); end
    total++; if (f_count !== 3'd0) begin bad++; $display("FAIL rst_fwft_count got=%0d want=0", f_count); end
    total++; if ({f_full, f_empty, f_af, f_ae} !== 4'b0101) begin
      bad++; $display("FAIL rst_fwft_flags got=%b want=0101", {f_full, f_empty, f_af, f_ae}); end
    total++; if ({f_valid, f_ovf, f_unf} !== 3'b000) begin
      bad++; $display("FAIL rst_fwft_pulses got=%b want=000", {f_valid, f_ovf, f_unf}); end
    total++; if (f_rdata !== 8'h00) begin bad++; $display("FAIL rst_fwft_data got=%h want=00", f_rdata); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  // Fill 0x11..0x55 while stepping counts 1..5 through the thresholds, then overflow.
  task automatic test_fill_thresholds();
    logic [3:0] ef;
    for (int n = 1; n <= 5; n++) begin
      s_wr = 1'b1; s_wdata = 8'(n * 17);
      tick();
      ef = {(n == 5), 1'b0, (n >= 3), (n <= 1)};
      total++; if (s_count !== 3'(n)) begin bad++; $display("FAIL fill_count got=%0d want=%0d", s_count, n); end
      total++; if ({s_full, s_empty, s_af, s_ae} !== ef) begin
        bad++; $display("FAIL fill_flags n=%0d got=%b want=%b", n, {s_full, s_empty, s_af, s_ae}, ef); end
    end
    s_wdata = 8'h66;
    tick();
    total++; if ({s_ovf, s_count} !== {1'b1, 3'd5}) begin
      bad++; $display("FAIL ovf_pulse got=%b/%0d want=1/5", s_ovf, s_count); end
    s_wr = 1'b0;
    tick();
    total++; if ({s_ovf, s_count} !== {1'b0, 3'd5}) begin
      bad++; $display("FAIL ovf_once got=%b/%0d want=0/5", s_ovf, s_count); end
  endtask

  task automatic test_full_rw();
    logic [7:0] exp_q [5] = '{8'h22, 8'h33, 8'h44, 8'h55, 8'hAA};
    s_wr = 1'b1; s_rd = 1'b1; s_wdata = 8'hAA;
    tick();
    total++; if ({s_ovf, s_count} !== {1'b0, 3'd5}) begin
      bad++; $display("FAIL full_rw_accept got=%b/%0d want=0/5", s_ovf, s_count); end
    total++; if ({s_valid, s_rdata} !== {1'b1, 8'h11}) begin
      bad++; $display("FAIL full_rw_data got=%b/%h want=1/11", s_valid, s_rdata); end
    s_wr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if ({s_valid, s_rdata} !== {1'b1, exp_q[i]}) begin
        bad++; $display("FAIL drain_data i=%0d got=%b/%h want=1/%h", i, s_valid, s_rdata, exp_q[i]); end
    end
    s_rd = 1'b0;
    tick();
    total++; if ({s_valid, s_rdata, s_unf} !== {1'b0, 8'hAA, 1'b0}) begin
      bad++; $display("FAIL drain_hold got=%b/%h/%b want=0/aa/0", s_valid, s_rdata, s_unf); end
    total++; if ({s_full, s_empty, s_af, s_ae, s_count} !== {4'b0101, 3'd0}) begin
      bad++; $display("FAIL drain_empty got=%b/%0d want=0101/0", {s_full, s_empty, s_af, s_ae}, s_count); end
  endtask

  task automatic test_empty();
    s_rd = 1'b1;
    tick();
    total++; if ({s_unf, s_valid, s_count} !== {2'b10, 3'd0}) begin
      bad++; $display("FAIL unf_alone got=%b%b/%0d want=10/0", s_unf, s_valid, s_count); end
    s_rd = 1'b0;
    tick();
    total++; if (s_unf !== 1'b0) begin bad++; $display("FAIL unf_clear got=%b want=0", s_unf); end
    s_rd = 1'b1; s_wr = 1'b1; s_wdata = 8'h3C;
    tick();
    total++; if ({s_unf, s_valid, s_count} !== {2'b10, 3'd1}) begin
      bad++; $display("FAIL unf_rw got=%b%b/%0d want=10/1", s_unf, s_valid, s_count); end
    s_wr = 1'b0;
    tick();
    total++; if ({s_unf, s_valid, s_rdata, s_count} !== {2'b01, 8'h3C, 3'd0}) begin
      bad++; $display("FAIL unf_rw_read got=%b%b/%h/%0d want=01/3c/0", s_unf, s_valid, s_rdata, s_count); end
    s_rd = 1'b0;
    tick();
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 12; i++) begin
      s_wr = 1'b1; s_wdata = 8'(i);
      tick();
      total++; if (s_count !== 3'd1) begin bad++; $display("FAIL wrap_wcount i=%0d got=%0d want=1", i, s_count); end
      s_wr = 1'b0; s_rd = 1'b1;
      tick();
      total++; if ({s_valid, s_rdata, s_count} !== {1'b1, 8'(i), 3'd0}) begin
        bad++; $display("FAIL wrap_read i=%0d got=%b/%h/%0d want=1/%h/0", i, s_valid, s_rdata, s_count, 8'(i)); end
      s_rd = 1'b0;
    end
    tick();
  endtask

  task automatic test_fwft();
    f_wr = 1'b1; f_wdata = 8'h7E;
    tick();
    f_wr = 1'b0;
    total++; if ({f_valid, f_rdata, f_count} !== {1'b1, 8'h7E, 3'd1}) begin
      bad++; $display("FAIL fwft_fall got=%b/%h/%0d want=1/7e/1", f_valid, f_rdata, f_count); end
    f_rd = 1'b1;
    tick();
    f_rd = 1'b0;
    total++; if ({f_valid, f_empty, f_unf} !== 3'b010) begin
      bad++; $display("FAIL fwft_pop got=%b want=010", {f_valid, f_empty, f_unf}); end
    f_wr = 1'b1; f_wdata = 8'h01;
    tick();
    f_wdata = 8'h02;
    tick();
    f_wr = 1'b0;
    total++; if ({f_valid, f_rdata, f_count} !== {1'b1, 8'h01, 3'd2}) begin
      bad++; $display("FAIL fwft_head got=%b/%h/%0d want=1/01/2", f_valid, f_rdata, f_count); end
    f_rd = 1'b1;
    tick();
    total++; if ({f_valid, f_rdata} !== {1'b1, 8'h02}) begin
      bad++; $display("FAIL fwft_next got=%b/%h want=1/02", f_valid, f_rdata); end
    tick();
    f_rd = 1'b0;
    total++; if ({f_valid, f_count, f_unf} !== {1'b0, 3'd0, 1'b0}) begin
      bad++; $display("FAIL fwft_drain got=%b/%0d/%b want=0/0/0", f_valid, f_count, f_unf); end
  endtask

  task automatic test_async_reset();
    s_wr = 1'b1; s_wdata = 8'h5A;
    tick();
    s_wdata = 8'h5B;
    tick();
    s_wr = 1'b0; s_rd = 1'b1;
    tick();
    total++; if ({s_valid, s_rdata, s_count} !== {1'b1, 8'h5A, 3'd1}) begin
      bad++; $display("FAIL pre_reset got=%b/%h/%0d want=1/5a/1", s_valid, s_rdata, s_count); end
    s_rd = 1'b0; s_wr = 1'b1; s_wdata = 8'h77;
    #1 rst_n = 1'b0;
    #1;
    total++; if ({s_full, s_empty, s_af, s_ae, s_count} !== {4'b0101, 3'd0}) begin
      bad++; $display("FAIL async_flags got=%b/%0d want=0101/0", {s_full, s_empty, s_af, s_ae}, s_count); end
    total++; if ({s_valid, s_rdata, s_ovf, s_unf} !== {1'b0, 8'h00, 2'b00}) begin
      bad++; $display("FAIL async_out got=%b/%h/%b%b want=0/00/00", s_valid, s_rdata, s_ovf, s_unf); end
    #1 rst_n = 1'b1;
    s_wr = 1'b0;
    tick();
    total++; if ({s_empty, s_count} !== {1'b1, 3'd0}) begin
      bad++; $display("FAIL post_reset got=%b/%0d want=1/0", s_empty, s_count); end
  endtask

  initial begin
    s_wr = 1'b0; s_rd = 1'b0; s_wdata = '0;
    f_wr = 1'b0; f_rd = 1'b0; f_wdata = '0;
    test_reset();
    test_fill_thresholds();
    test_full_rw();
    test_empty();
    test_wrap();
    test_fwft();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fifo_sync_flex.md
# fifo_sync_flex

Parametrised single-clock FIFO, successor to the team's basic synchronous FIFO. Adds arbitrary (non-power-of-2) depth, selectable standard or first-word-fall-through (FWFT) read mode, occupancy count, programmable almost-full/almost-empty flags, overflow/underflow error pulses and read/write pass-through when full. Used as the general-purpose stream buffer between pipeline stages in one clock domain.

## Interface
- DataWidth, 32, word width in bits
- FifoDepth, 8, storage words; any value >= 2
- AlmostFullThresh, 6, o_almost_full asserts when count >= this; legal range 1..FifoDepth
- AlmostEmptyThresh, 2, o_almost_empty asserts when count <= this; legal range 0..FifoDepth-1
- FwftMode, 0, 0 = standard registered read, 1 = first-word-fall-through
- Illegal parameter values cause an elaboration-time error.

- clk  in  1  clock, all logic on rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_write  in  1  write request
- i_write_data  in  DataWidth  write word
- i_read  in  1  read (standard) / pop (FWFT) request
- o_read_data  out  DataWidth  read word
- o_read_valid  out  1  o_read_data holds a valid word (see Operation)
- o_full  out  1  count == FifoDepth
- o_empty  out  1  count == 0
- o_almost_full  out  1  count >= AlmostFullThresh
- o_almost_empty  out  1  count <= AlmostEmptyThresh
- o_count  out  $clog2(FifoDepth+1)  occupancy, 0..FifoDepth
- o_overflow  out  1  one-cycle pulse: write rejected
- o_underflow  out  1  one-cycle pulse: read rejected

## Operation
- State: write pointer, read pointer (each 0..FifoDepth-1, wrap FifoDepth-1 -> 0, no power-of-2 requirement), registered count. Full/empty derived from count only, not pointer MSBs.
- read_en = i_read && count != 0.
- write_en = i_write && (count != FifoDepth || read_en). Full with simultaneous accepted read: both accepted, count unchanged.
- Empty with simultaneous read and write: write accepted, read rejected, count 0 -> 1, o_underflow pulses.
- Count update: +1 write-only, -1 read-only, unchanged for both or neither; never leaves 0..FifoDepth.
- Standard mode: accepted read loads memory[read pointer] into o_read_data register; o_read_valid high for exactly the following cycle; o_read_data holds last value otherwise.
- FWFT mode: o_read_data = memory[read pointer] combinationally; o_read_valid = !o_empty; i_read with valid data pops the head.
- Flags o_full, o_empty, o_almost_* are decoded from the registered count only (no dependence on current-cycle requests).
- o_overflow registered: high the cycle after i_write && !write_en. o_underflow registered: high the cycle after i_read && !read_en.
- Memory contents not reset; reads never return unwritten locations.

## Timing
- Reset asserted (async, immediate): pointers 0, count 0, o_empty 1, o_full 0, o_almost_empty 1, o_almost_full 0, o_read_data 0, o_read_valid 0, o_overflow 0, o_underflow 0. Reset mid-operation discards all contents; in-flight requests that cycle are ignored.
- After deassertion the first rising edge is a normal operating edge.
- Write at edge N: o_count, flags updated after edge N; FWFT o_read_valid/o_read_data visible after edge N (write-to-read latency 1 cycle).
- Standard read accepted at edge N: o_read_data/o_read_valid valid after edge N, deasserted after edge N+1 unless another read accepted.
- Full throughput: one write and one read per cycle sustained at any occupancy (except read when empty).

## Test plan
- DataWidth=8, FifoDepth=5, standard: write 0x11..0x55 on 5 consecutive cycles -> o_count 5, o_full 1, o_almost_full 1; 6th write 0x66 -> o_overflow pulses once, count stays 5; read 5 -> data 0x11..0x55 in order, one cycle after each read, o_read_valid high each.
- Wrap: FifoDepth=5, 12 interleaved write/read pairs with data 0x00..0x0B -> read data in order, pointers wrap at 4 -> 0, o_count never exceeds 1.
- Full with simultaneous read+write (0xAA) -> both accepted, no o_overflow, count 5; 0xAA emerges after the 5 older words.
- Empty: read alone -> o_underflow pulse, count 0; read+write 0x3C -> o_underflow pulse, count 1, next read returns 0x3C.
- FwftMode=1: write 0x7E at edge N -> o_read_valid 1 and o_read_data 0x7E after edge N without a read; pop -> o_read_valid 0.
- Thresholds 3/1: counts 0..5 stepped -> o_almost_empty high at 0,1; o_almost_full high at 3,4,5; async reset asserted mid-stream -> all outputs to reset values before next clock edge.
